// File: rtl/id_stall_ctrl_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/stall controller.
// Holds register-number width, the hard-wired zero register and the tracking-entry layout.
package id_stall_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned ENTRY_W = REG_W + 2;
    localparam int unsigned CNT_W   = 16;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } track_entry_t;

    localparam track_entry_t ENTRY_NONE = '0;

    function automatic track_entry_t make_entry(
        input logic [REG_W-1:0] rd,
        input logic             reg_write,
        input logic             mem_read
    );
        track_entry_t e;
        e.rd        = rd;
        e.reg_write = reg_write;
        e.mem_read  = mem_read;
        return e;
    endfunction

endpackage

// File: rtl/id_hazard_cmp.sv
// Compares one tracked destination entry against the ID instruction's sources.
// The zero register and non-writing entries never produce a hit.
module id_hazard_cmp
    import id_stall_ctrl_pkg::*;
(
    input  track_entry_t     entry,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    output logic             hit
);

    logic live;

    always_comb begin
        live = entry.reg_write && (entry.rd != REG_ZERO);
        hit  = live && ((use_rs && (entry.rd == rs)) || (use_rt && (entry.rd == rt)));
    end

endmodule

// File: rtl/id_stall_ctrl.sv
// ID-stage stall controller: tracks ID_EX/EX_MEM/MEM_WB destinations and raises
// load-use and branch-operand stalls; also counts stall cycles (saturating).
module id_stall_ctrl
    import id_stall_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_ID_Rs,
    input  logic [REG_W-1:0] i_ID_Rt,
    input  logic             i_ID_use_Rs,
    input  logic             i_ID_use_Rt,
    input  logic             i_ID_branch,
    input  logic [REG_W-1:0] i_ID_Rd,
    input  logic             i_ID_reg_write,
    input  logic             i_ID_mem_read,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_bubble,
    output logic [REG_W-1:0] o_EX_MEM_Rd,
    output logic [REG_W-1:0] o_MEM_WB_Rd,
    output logic             o_EX_MEM_reg_write,
    output logic             o_MEM_WB_reg_write,
    output logic [CNT_W-1:0] o_stall_count
);

    track_entry_t     id_ex;
    track_entry_t     ex_mem;
    track_entry_t     mem_wb;
    logic             id_ex_hit;
    logic             ex_mem_hit;
    logic             mem_wb_hit;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_count;

    id_hazard_cmp u_cmp_id_ex (
        .entry  (id_ex),
        .rs     (i_ID_Rs),
        .rt     (i_ID_Rt),
        .use_rs (i_ID_use_Rs),
        .use_rt (i_ID_use_Rt),
        .hit    (id_ex_hit)
    );

    id_hazard_cmp u_cmp_ex_mem (
        .entry  (ex_mem),
        .rs     (i_ID_Rs),
        .rt     (i_ID_Rt),
        .use_rs (i_ID_use_Rs),
        .use_rt (i_ID_use_Rt),
        .hit    (ex_mem_hit)
    );

    // Write-before-read register file: a MEM_WB hit is always forwardable, never a stall.
    id_hazard_cmp u_cmp_mem_wb (
        .entry  (mem_wb),
        .rs     (i_ID_Rs),
        .rt     (i_ID_Rt),
        .use_rs (i_ID_use_Rs),
        .use_rt (i_ID_use_Rt),
        .hit    (mem_wb_hit)
    );

    // Branches resolve in ID, so they wait on any ID_EX producer and on an EX_MEM load.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        if (!i_flush) begin
            stall = (id_ex_hit && (i_ID_branch || id_ex.mem_read))
                 || (i_ID_branch && ex_mem_hit && ex_mem.mem_read);
        end
        bubble = stall || i_flush;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            id_ex       <= ENTRY_NONE;
            ex_mem      <= ENTRY_NONE;
            mem_wb      <= ENTRY_NONE;
            stall_count <= '0;
        end else begin
            mem_wb <= ex_mem;
            ex_mem <= id_ex;
            id_ex  <= bubble ? ENTRY_NONE
                             : make_entry(i_ID_Rd, i_ID_reg_write, i_ID_mem_read);
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    assign o_stall            = stall;
    assign o_bubble           = bubble;
    assign o_EX_MEM_Rd        = ex_mem.rd;
    assign o_EX_MEM_reg_write = ex_mem.reg_write;
    assign o_MEM_WB_Rd        = mem_wb.rd;
    assign o_MEM_WB_reg_write = mem_wb.reg_write;
    assign o_stall_count      = stall_count;

endmodule

// File: tb/tb_id_stall_ctrl.sv
// Directed testbench for id_stall_ctrl: instruction sequences with hand-computed
// stall/bubble/tracking expectations.
module tb_id_stall_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_branch;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic        stall;
    logic        bubble;
    logic [4:0]  ex_mem_rd;
    logic [4:0]  mem_wb_rd;
    logic        ex_mem_reg_write;
    logic        mem_wb_reg_write;
    logic [15:0] stall_count;

    int unsigned n_tests;
    int unsigned n_fail;

    id_stall_ctrl dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_ID_Rs            (id_rs),
        .i_ID_Rt            (id_rt),
        .i_ID_use_Rs        (id_use_rs),
        .i_ID_use_Rt        (id_use_rt),
        .i_ID_branch        (id_branch),
        .i_ID_Rd            (id_rd),
        .i_ID_reg_write     (id_reg_write),
        .i_ID_mem_read      (id_mem_read),
        .i_flush            (flush),
        .o_stall            (stall),
        .o_bubble           (bubble),
        .o_EX_MEM_Rd        (ex_mem_rd),
        .o_MEM_WB_Rd        (mem_wb_rd),
        .o_EX_MEM_reg_write (ex_mem_reg_write),
        .o_MEM_WB_reg_write (mem_wb_reg_write),
        .o_stall_count      (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic br, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_branch = br; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        flush = 1'b0;
        nop();
        #12;
        check("rst_stall", stall, 0);
        check("rst_bubble", bubble, 0);
        check("rst_exmem_rd", ex_mem_rd, 0);
        check("rst_count", stall_count, 0);
        rst = 1'b0;
        tick();

        // lw $8 ; beq $8,$9 -> two stall cycles, resolves with MEM_WB forward
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        check("lwbeq_c0", stall, 0);
        tick();
        set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("lwbeq_c1_stall", stall, 1);
        check("lwbeq_c1_bubble", bubble, 1);
        tick();
        check("lwbeq_c2_stall", stall, 1);
        check("lwbeq_c2_exmem_rd", ex_mem_rd, 8);
        tick();
        check("lwbeq_c3_stall", stall, 0);
        check("lwbeq_c3_memwb_rd", mem_wb_rd, 8);
        check("lwbeq_c3_memwb_rw", mem_wb_reg_write, 1);
        check("lwbeq_count", stall_count, 2);
        tick();
        drain();

        // add $8 ; beq $8,$0 -> one stall, then EX_MEM forward
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        tick();
        set_id(5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("addbeq_c1_stall", stall, 1);
        tick();
        check("addbeq_c2_stall", stall, 0);
        check("addbeq_c2_exmem_rd", ex_mem_rd, 8);
        check("addbeq_c2_exmem_rw", ex_mem_reg_write, 1);
        tick();
        check("addbeq_count", stall_count, 3);
        drain();

        // lw $8 ; add $10,$8,$9 -> one stall
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        check("lwadd_c1_stall", stall, 1);
        tick();
        check("lwadd_c2_stall", stall, 0);
        tick();
        check("lwadd_count", stall_count, 4);
        drain();

        // lw $8 ; add $10,$9,$9 -> no stall
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        check("lwadd_nodep_stall", stall, 0);
        tick();
        drain();

        // lw $0 ; beq $0,$0 -> zero register never stalls
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("lw0_beq0_c1", stall, 0);
        tick();
        check("lw0_beq0_c2", stall, 0);
        tick();
        drain();

        // lw $8 ; add with Rs=$8 but use_Rs=0 -> no stall
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd9, 1'b0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        check("unused_rs_stall", stall, 0);
        tick();
        check("nostall_count", stall_count, 4);
        drain();

        // stall condition with flush -> flush wins, ID_EX zeroed
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", stall, 0);
        check("flush_bubble", bubble, 1);
        tick();
        flush = 1'b0;
        nop();
        check("flush_exmem_lw", ex_mem_rd, 8);
        tick();
        check("flush_idex_rd", ex_mem_rd, 0);
        check("flush_idex_rw", ex_mem_reg_write, 0);
        check("flush_count", stall_count, 4);
        drain();

        // reset in the middle of a two-cycle branch stall
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("rstmid_stall_pre", stall, 1);
        tick();
        check("rstmid_stall_c2", stall, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_stall", stall, 0);
        check("rstmid_bubble", bubble, 0);
        check("rstmid_exmem_rd", ex_mem_rd, 0);
        check("rstmid_exmem_rw", ex_mem_reg_write, 0);
        check("rstmid_memwb_rd", mem_wb_rd, 0);
        check("rstmid_count", stall_count, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_no_hazard", stall, 0);
        check("post_rst_count", stall_count, 0);
        tick();
        check("post_rst_count2", stall_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
